// File: rtl/apl_pkg.sv
// Shared constants and types for the OpenCAPI request arbiter and its helpers.
package apl_pkg;

  localparam int nstrms       = 64;
  localparam int nstrms_width = $clog2(nstrms);
  localparam int channels     = 4;
  localparam int addr_width   = 64;
  localparam int max_outst    = 256;
  localparam int cnt_width    = $clog2(max_outst + 1);
  localparam int ptr_width    = (channels > 1) ? $clog2(channels) : 1;

  typedef logic [nstrms_width-1:0] sid_t;
  typedef logic [addr_width-1:0]   ea_t;
  typedef logic [cnt_width-1:0]    cnt_t;
  typedef logic [ptr_width-1:0]    ptr_t;

  localparam cnt_t max_cnt = cnt_t'(max_outst);

  // Round-robin pointer advance: the channel after the winner, wrapping.
  function automatic ptr_t ptr_next(input ptr_t p);
    if (p == ptr_t'(channels - 1)) return '0;
    return ptr_t'(p + ptr_t'(1));
  endfunction

endpackage

// File: rtl/apl_req_arb_if.sv
// Request/response bundle between the L2 channel controllers, the arbiter and
// the OpenCAPI request pins.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both high. Valid, once raised, is held with its
// payload until it transfers; ready may depend combinationally on valid.
interface apl_req_arb_if;
  import apl_pkg::*;

  logic [channels-1:0]              i_req_v;
  logic [channels-1:0]              i_req_r;
  logic [channels*nstrms_width-1:0] i_req_sid;
  logic [channels*addr_width-1:0]   i_req_ea;
  logic                             o_req_v;
  logic                             o_req_r;
  sid_t                             o_req_sid;
  ea_t                              o_req_ea;
  logic                             i_rsp_v;
  logic                             i_rsp_r;
  sid_t                             i_rsp_sid;

  // Arbiter side.
  modport slave (
    input  i_req_v, i_req_sid, i_req_ea, o_req_r, i_rsp_v, i_rsp_sid,
    output i_req_r, o_req_v, o_req_sid, o_req_ea, i_rsp_r
  );

  // Channel controllers / OpenCAPI side.
  modport master (
    output i_req_v, i_req_sid, i_req_ea, o_req_r, i_rsp_v, i_rsp_sid,
    input  i_req_r, o_req_v, o_req_sid, o_req_ea, i_rsp_r
  );

endinterface

// File: rtl/apl_rr_pick.sv
// Combinational round-robin picker: first set bit of elig_i searching upward
// from ptr_i with wrap. Shared with the L1 read-port arbiter.
module apl_rr_pick #(
  parameter int n  = 4,
  parameter int pw = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0]  elig_i,
  input  logic [pw-1:0] ptr_i,
  output logic [n-1:0]  gnt_o,
  output logic [pw-1:0] idx_o,
  output logic          any_o
);

  // Rotating priority search; the first hit wins.
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < n; i++) begin
      j = (int'(ptr_i) + i) % n;
      if (!any_o && elig_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = pw'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apl_req_arb.sv
// Round-robin arbiter sharing the OpenCAPI request port among the L2 channels,
// with a per-stream credit counter capping in-flight cache-line requests.
module apl_req_arb
  import apl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  apl_req_arb_if.slave      bus,
  output logic [nstrms-1:0] o_outst_zero,
  output logic              o_err
);

  sid_t                req_sid [channels];
  ea_t                 req_ea  [channels];
  cnt_t                cnt_q   [nstrms];
  cnt_t                cnt_d   [nstrms];
  logic [channels-1:0] elig;
  logic [channels-1:0] pick_gnt;
  ptr_t                pick_idx;
  logic                pick_any;
  ptr_t                ptr_q;
  logic                o_req_v_q;
  sid_t                o_req_sid_q;
  ea_t                 o_req_ea_q;
  logic                rsp_r_q;
  logic                err_q;
  logic                slot_free;
  logic                grant_v;
  sid_t                gnt_sid;
  ea_t                 gnt_ea;
  logic                rsp_fire;
  logic                underflow;

  // Slice the flat channel buses and flag channels that still hold credit.
  always_comb begin
    for (int k = 0; k < channels; k++) begin
      req_sid[k] = bus.i_req_sid[k*nstrms_width +: nstrms_width];
      req_ea[k]  = bus.i_req_ea[k*addr_width +: addr_width];
      elig[k]    = bus.i_req_v[k] && (cnt_q[req_sid[k]] < max_cnt);
    end
  end

  apl_rr_pick #(.n(channels), .pw(ptr_width)) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // No grant while the output register holds an unaccepted request.
  assign slot_free = !o_req_v_q || bus.o_req_r;
  assign grant_v   = slot_free && pick_any;
  assign gnt_sid   = req_sid[pick_idx];
  assign gnt_ea    = req_ea[pick_idx];
  assign rsp_fire  = bus.i_rsp_v && rsp_r_q;

  assign bus.i_req_r   = grant_v ? pick_gnt : '0;
  assign bus.o_req_v   = o_req_v_q;
  assign bus.o_req_sid = o_req_sid_q;
  assign bus.o_req_ea  = o_req_ea_q;
  assign bus.i_rsp_r   = rsp_r_q;
  assign o_err         = err_q;

  // Next counter values; a same-sid grant and response cancel out.
  always_comb begin
    logic inc;
    logic dec;
    underflow = rsp_fire && (cnt_q[bus.i_rsp_sid] == '0) &&
                !(grant_v && (gnt_sid == bus.i_rsp_sid));
    for (int s = 0; s < nstrms; s++) begin
      inc      = grant_v && (gnt_sid == sid_t'(s));
      dec      = rsp_fire && (bus.i_rsp_sid == sid_t'(s)) &&
                 ((cnt_q[s] != '0) || inc);
      cnt_d[s] = cnt_q[s];
      if (inc && !dec)      cnt_d[s] = cnt_q[s] + cnt_t'(1);
      else if (dec && !inc) cnt_d[s] = cnt_q[s] - cnt_t'(1);
      o_outst_zero[s] = (cnt_q[s] == '0);
    end
  end

  // Per-stream credit counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < nstrms; s++) cnt_q[s] <= '0;
    end else begin
      for (int s = 0; s < nstrms; s++) cnt_q[s] <= cnt_d[s];
    end
  end

  // Output register, RR pointer, response ready and sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_req_v_q   <= 1'b0;
      o_req_sid_q <= '0;
      o_req_ea_q  <= '0;
      ptr_q       <= '0;
      rsp_r_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rsp_r_q <= 1'b1;
      if (underflow) err_q <= 1'b1;
      if (slot_free) begin
        o_req_v_q <= pick_any;
        if (pick_any) begin
          o_req_sid_q <= gnt_sid;
          o_req_ea_q  <= gnt_ea;
          ptr_q       <= ptr_next(pick_idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_apl_req_arb.sv
// Directed bench for apl_req_arb: reset state, single grant, round-robin order,
// stall hold, credit limit, simultaneous grant/response, underflow, and reset
// while a request is in flight.
module tb_apl_req_arb;
  import apl_pkg::*;

  logic              clk;
  logic              reset;
  logic [nstrms-1:0] outst_zero;
  logic              err;
  int                nerr;
  int                nchk;
  int                n;

  apl_req_arb_if bus ();

  apl_req_arb dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .o_outst_zero (outst_zero),
    .o_err        (err)
  );

  // Clock / reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic v, input int sid, input logic [63:0] ea);
    bus.i_req_v[k]                           = v;
    bus.i_req_sid[k*nstrms_width +: nstrms_width] = sid_t'(sid);
    bus.i_req_ea[k*addr_width +: addr_width]     = ea;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] e_gnt;
    nerr = 0;
    nchk = 0;
    reset         = 1'b1;
    bus.i_req_v   = '0;
    bus.i_req_sid = '0;
    bus.i_req_ea  = '0;
    bus.o_req_r   = 1'b0;
    bus.i_rsp_v   = 1'b0;
    bus.i_rsp_sid = '0;

    // Reset state.
    repeat (2) tick();
    chk("rst_o_req_v", bus.o_req_v, 0);
    chk("rst_o_req_sid", bus.o_req_sid, 0);
    chk("rst_o_req_ea", bus.o_req_ea, 0);
    chk("rst_outst_zero", outst_zero, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_err", err, 0);
    chk("rst_rsp_r", bus.i_rsp_r, 0);
    chk("rst_ptr", dut.ptr_q, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rsp_r_after_reset", bus.i_rsp_r, 1);

    // Single request ch0 sid=1 ea=16.
    bus.o_req_r = 1'b1;
    set_ch(0, 1'b1, 1, 64'd16);
    #1;
    chk("single_gnt", bus.i_req_r, 4'b0001);
    tick();
    set_ch(0, 1'b0, 0, 64'd0);
    chk("single_v", bus.o_req_v, 1);
    chk("single_sid", bus.o_req_sid, 1);
    chk("single_ea", bus.o_req_ea, 16);
    chk("single_cnt1", dut.cnt_q[1], 1);
    chk("single_zero1", outst_zero[1], 0);
    chk("single_ptr", dut.ptr_q, 1);

    // ch3 alone: pointer wraps back to 0.
    set_ch(3, 1'b1, 2, 64'h40);
    #1;
    chk("wrap_gnt", bus.i_req_r, 4'b1000);
    tick();
    set_ch(3, 1'b0, 0, 64'd0);
    chk("wrap_sid", bus.o_req_sid, 2);
    chk("wrap_ptr", dut.ptr_q, 0);

    // Round robin, all four channels valid, one grant per cycle.
    for (int k = 0; k < 4; k++) set_ch(k, 1'b1, 16*k, 64'h1000 + 64'h40*k);
    for (int i = 0; i < 8; i++) begin
      e_gnt = 4'(1 << (i % 4));
      #1;
      chk("rr_gnt", bus.i_req_r, e_gnt);
      tick();
      chk("rr_sid", bus.o_req_sid, 16*(i % 4));
      chk("rr_ea", bus.o_req_ea, 64'h1000 + 64'h40*(i % 4));
      chk("rr_v", bus.o_req_v, 1);
    end

    // Stall: output held, no grants.
    bus.o_req_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_gnt", bus.i_req_r, 4'b0000);
      tick();
      chk("hold_sid", bus.o_req_sid, 48);
      chk("hold_ea", bus.o_req_ea, 64'h10c0);
      chk("hold_v", bus.o_req_v, 1);
    end
    chk("hold_cnt48", dut.cnt_q[48], 2);
    for (int k = 0; k < 4; k++) set_ch(k, 1'b0, 0, 64'd0);
    bus.o_req_r = 1'b1;
    tick();
    chk("drain_v", bus.o_req_v, 0);

    // Credit limit on sid 5.
    set_ch(1, 1'b1, 5, 64'h5000);
    n = 0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (!bus.i_req_r[1]) break;
      n++;
      tick();
    end
    chk("credit_grants", n, 256);
    chk("credit_cnt5", dut.cnt_q[5], 256);
    set_ch(2, 1'b1, 6, 64'h6000);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("credit_other_gnt", bus.i_req_r, 4'b0100);
      tick();
    end
    bus.i_rsp_v   = 1'b1;
    bus.i_rsp_sid = sid_t'(5);
    #1;
    chk("credit_rsp_gnt", bus.i_req_r, 4'b0100);
    tick();
    bus.i_rsp_v = 1'b0;
    chk("credit_cnt5_dec", dut.cnt_q[5], 255);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.i_req_r[1]) n++;
      tick();
    end
    chk("credit_one_more", n, 1);
    chk("credit_cnt5_full", dut.cnt_q[5], 256);
    set_ch(1, 1'b0, 0, 64'd0);
    set_ch(2, 1'b0, 0, 64'd0);
    tick();

    // Simultaneous grant and response.
    set_ch(0, 1'b1, 3, 64'h3000);
    repeat (7) tick();
    chk("sim_cnt3_7", dut.cnt_q[3], 7);
    set_ch(0, 1'b1, 4, 64'h4000);
    repeat (2) tick();
    chk("sim_cnt4_2", dut.cnt_q[4], 2);
    set_ch(0, 1'b1, 3, 64'h3000);
    bus.i_rsp_v   = 1'b1;
    bus.i_rsp_sid = sid_t'(3);
    tick();
    chk("sim_same_cnt3", dut.cnt_q[3], 7);
    chk("sim_same_sid", bus.o_req_sid, 3);
    bus.i_rsp_sid = sid_t'(4);
    tick();
    bus.i_rsp_v = 1'b0;
    set_ch(0, 1'b0, 0, 64'd0);
    chk("sim_diff_cnt3", dut.cnt_q[3], 8);
    chk("sim_diff_cnt4", dut.cnt_q[4], 1);
    chk("sim_err", err, 0);

    // Underflow on sid 9.
    bus.i_rsp_v   = 1'b1;
    bus.i_rsp_sid = sid_t'(9);
    tick();
    bus.i_rsp_v = 1'b0;
    chk("uf_err", err, 1);
    chk("uf_cnt9", dut.cnt_q[9], 0);
    chk("uf_zero9", outst_zero[9], 1);
    repeat (3) tick();
    chk("uf_err_sticky", err, 1);

    // Reset while a request is in flight.
    bus.o_req_r = 1'b0;
    set_ch(0, 1'b1, 10, 64'hA000);
    tick();
    set_ch(0, 1'b0, 0, 64'd0);
    tick();
    chk("mid_v_before", bus.o_req_v, 1);
    chk("mid_sid_before", bus.o_req_sid, 10);
    chk("mid_ptr_before", dut.ptr_q, 1);
    reset = 1'b1;
    #1;
    chk("mid_v_async", bus.o_req_v, 0);
    chk("mid_zero_all", outst_zero, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mid_ptr", dut.ptr_q, 0);
    chk("mid_err", err, 0);
    chk("mid_rsp_r", bus.i_rsp_r, 0);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) set_ch(k, 1'b1, 20 + k, 64'h2000 + 64'h40*k);
    bus.o_req_r = 1'b1;
    #1;
    chk("post_gnt", bus.i_req_r, 4'b0001);
    tick();
    chk("post_sid", bus.o_req_sid, 20);
    chk("post_v", bus.o_req_v, 1);
    for (int k = 0; k < 4; k++) set_ch(k, 1'b0, 0, 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/apl_req_arb.md
Name: apl_req_arb

Overview:
- Shares the single OpenCAPI 3.0 request port among the `channels` L2 channel fetch engines.
- Arbitration is round-robin.
- Per-stream outstanding-request counters throttle each stream. A stream may not have more than `max_outst` cache-line requests in flight; each response returns one credit.
- Sits between the L2 channel controllers and the `o_req_*`/`i_rsp_*` pins of `apl_top`.

Parameters:
- nstrms, 64, total streams.
- nstrms_width, $clog2(nstrms), stream id width.
- channels, 4, number of requesting L2 channels.
- addr_width, 64, host effective address width.
- max_outst, 256, maximum in-flight requests per stream.
- cnt_width, $clog2(max_outst+1), counter width (9 at default).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- i_req_v  in  channels  per-channel request valid.
- i_req_r  out  channels  per-channel request ready (grant).
- i_req_sid  in  channels*nstrms_width  per-channel stream id, channel k at slice k.
- i_req_ea  in  channels*addr_width  per-channel cache-line EA.
- o_req_v  out  1  request valid to OpenCAPI.
- o_req_r  in  1  OpenCAPI ready.
- o_req_sid  out  nstrms_width  granted stream id.
- o_req_ea  out  addr_width  granted EA.
- i_rsp_v  in  1  response valid (one cache line returned).
- i_rsp_r  out  1  response ready.
- i_rsp_sid  in  nstrms_width  response stream id.
- o_outst_zero  out  nstrms  per-stream flag, counter == 0 (used by the stream-reset path to drain).
- o_err  out  1  sticky flag: credit underflow.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-high (`reset`).
- Reset values:
  - o_req_v=0, o_req_sid=0, o_req_ea=0.
  - All counters 0, so o_outst_zero = all ones.
  - o_err=0.
  - RR pointer = 0, meaning channel 0 has highest priority.
  - i_rsp_r=0 while reset is high, and 1 from the first clock after reset deasserts.
- Eligibility: channel k is eligible iff i_req_v[k] and cnt[i_req_sid[k]] < max_outst.
- Output stage: a single register stage. The slot is free when !o_req_v or o_req_r.
- Grant:
  - When the slot is free, pick the first eligible channel searching from ptr, ptr+1, … mod channels.
  - i_req_r[k]=1 for the winner only. It is combinational from i_req_v, the counters, ptr and the slot-free term.
  - The winner's sid/ea load into the output register on that edge.
  - o_req_v=1 the next cycle, so latency from acceptance to o_req_v is 1 cycle.
  - ptr becomes winner+1 mod channels.
  - With no eligible channel and a free slot: o_req_v goes to 0 and ptr holds.
- Full throughput: with o_req_r held high, one grant per cycle.
- Output stability: o_req_sid/o_req_ea are stable while o_req_v && !o_req_r. No i_req_r is asserted in that case.
- Counters:
  - A grant increments cnt[sid] on the grant edge.
  - An accepted response (i_rsp_v && i_rsp_r) decrements cnt[i_rsp_sid].
  - Grant and response on the same sid in the same cycle: count unchanged.
  - Different sids in the same cycle: both updates apply.
- Full boundary: cnt == max_outst makes that stream's channel ineligible. Other channels are unaffected; there is no head-of-line blocking across channels.
- Underflow: a response to a sid with cnt == 0 leaves the counter at 0 and sets o_err. o_err clears only on reset.
- Duplicate sids: two channels presenting the same sid in one cycle is legal. Only one is granted per cycle, so the counter check stays exact.
- Reset mid-operation: all state clears asynchronously. An in-flight o_req is dropped; upstream must re-issue.

Decomposition:
- Package apl_pkg:
  - constants nstrms, nstrms_width, channels, addr_width, max_outst, cnt_width.
  - typedefs sid_t, ea_t, cnt_t.
- Sub-module apl_rr_pick:
  - Inputs: the eligible vector and ptr.
  - Outputs: one-hot grant plus a binary index.
  - Purely combinational, and reused by the L1 read-port arbiter.

Test Plan:
- Single request: ch0 sid=1 ea=16, o_req_r=1 → i_req_r[0] same cycle; o_req_v=1, sid=1, ea=16 next cycle; cnt[1]=1; o_outst_zero[1]=0.
- Round-robin: all 4 channels valid continuously (sids 0,16,32,48), o_req_r=1 → output order ch0,ch1,ch2,ch3,ch0…, one per cycle. Then hold o_req_r=0 for 3 cycles → output held stable and all i_req_r=0.
- Credit limit: ch1 sid=5 continuously, no responses → exactly 256 grants, then i_req_r[1]=0 while ch2 sid=6 is still granted every cycle. One i_rsp sid=5 → exactly one further grant for sid 5.
- Simultaneous: grant sid=3 and rsp sid=3 in the same cycle with cnt=7 → cnt stays 7. Grant sid=3 with rsp sid=4 (cnt[4]=2) → cnt[3]=8, cnt[4]=1.
- Underflow: rsp sid=9 with cnt 0 → o_err=1 next cycle and stays 1, cnt[9]=0.
- Reset mid-flight: assert reset while o_req_v=1 and counters are non-zero → o_req_v=0 immediately (asynchronous), o_outst_zero all ones, ptr=0, and ch0 wins first after release.
